// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback load tracker: memory source indices,
// address-nibble decode patterns, RISC-V opcodes and load funct3 codes, the
// packed load descriptor kept in the load queue, and helpers that decode a
// load into that descriptor.
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int XLEN_DEF = 32;

    // Index of each memory source in rsp_valid / rsp_data.
    typedef enum logic [1:0] {
        SRC_IO   = 2'd0,
        SRC_DMEM = 2'd1,
        SRC_BIOS = 2'd2
    } src_e;

    // Address bits [31:28] that select each source. DMEM is 4'b00?1, so it is
    // matched as (nibble & MASK) == VAL.
    localparam logic [3:0] NIB_IO        = 4'b1000;
    localparam logic [3:0] NIB_DMEM_MASK = 4'b1101;
    localparam logic [3:0] NIB_DMEM_VAL  = 4'b0001;
    localparam logic [3:0] NIB_BIOS      = 4'b0100;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [1:0] off;
        logic [2:0] funct3;
        src_e       src;
        logic       unmapped;
    } load_desc_t;

    function automatic logic is_load_f3(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Builds a queue entry. Offsets are forced to the access size so a
    // halfword never straddles lanes and a word always uses the full word.
    function automatic load_desc_t make_desc(input logic [4:0] rd,
                                             input logic [2:0] f3,
                                             input logic [3:0] nib,
                                             input logic [1:0] lo);
        load_desc_t d;
        d.rd       = rd;
        d.funct3   = f3;
        d.off      = lo;
        d.src      = SRC_IO;
        d.unmapped = 1'b0;
        if ((f3 == F3_LH) || (f3 == F3_LHU)) d.off = {lo[1], 1'b0};
        else if (f3 == F3_LW)                d.off = 2'b00;
        if (nib == NIB_IO)                                 d.src = SRC_IO;
        else if ((nib & NIB_DMEM_MASK) == NIB_DMEM_VAL)    d.src = SRC_DMEM;
        else if (nib == NIB_BIOS)                          d.src = SRC_BIOS;
        else                                               d.unmapped = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/wb_load_fmt.sv
// -----------------------------------------------------------------------------
// wb_load_fmt
// Combinational load data formatter: selects the byte or halfword lane of a
// returned memory word and sign- or zero-extends it.
// Ports:
//   i_word   [XLEN]  raw word from the memory source
//   i_off    [2]     byte offset within the word (addr[1:0], already aligned)
//   i_funct3 [3]     load funct3 (LB/LH/LW/LBU/LHU)
//   o_data   [XLEN]  formatted register write data
// -----------------------------------------------------------------------------
module wb_load_fmt
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch cannot be inferred.
        w_byte = i_word[7:0];
        o_data = i_word;
        case (i_off)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/wb_load_tracker.sv
// -----------------------------------------------------------------------------
// wb_load_tracker
// Writeback-stage controller. ALU/LUI/AUIPC and JAL/JALR results are written
// one cycle after issue; loads wait in an in-order DEPTH-entry queue until
// their memory source (IO, DMEM, BIOS) responds, then the formatted word is
// written. pending_mask marks destinations of queued loads for decode stalls.
// Optional feature macro: MISALIGN_CHECK_EN (misaligned LH/LHU/LW are dropped
// and flagged on load_err instead of being enqueued with forced alignment).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   issue_valid/ready          retiring instruction handshake (ready is comb)
//   issue_inst/addr/alu/pc4    instruction word, load address, ALU result, PC+4
//   rsp_valid[3], rsp_data     per-source responses (0 IO, 1 DMEM, 2 BIOS)
//   wb_valid/rd/data           registered register-file write port
//   pending_mask[32]           registered: rd bits of queued loads
//   load_err                   registered one-cycle misaligned-load pulse
// -----------------------------------------------------------------------------
module wb_load_tracker
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [31:0]       issue_inst,
    input  logic [XLEN-1:0]   issue_addr,
    input  logic [XLEN-1:0]   issue_alu,
    input  logic [XLEN-1:0]   issue_pc4,
    input  logic [2:0]        rsp_valid,
    input  logic [3*XLEN-1:0] rsp_data,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic [31:0]       pending_mask,
    output logic              load_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    load_desc_t          r_q [DEPTH];
    logic [DEPTH-1:0]    r_vld;
    logic [PW-1:0]       r_head, r_tail;
    logic [CW-1:0]       r_count;
    logic                r_wb_valid;
    logic [4:0]          r_wb_rd;
    logic [XLEN-1:0]     r_wb_data;
    logic [31:0]         r_pending_mask;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic        w_is_wr, w_sel_pc4, w_is_load, w_misalign, w_enq_load;
    logic        w_head_done, w_waw, w_fire, w_enq, w_deq;
    logic [2:0]  w_head_src_oh;
    logic [XLEN-1:0] w_rsp_word, w_fmt_data;
    logic [31:0] w_mask_next;
    load_desc_t  w_head, w_new_desc;
    logic        w_unused;

    assign w_opcode = issue_inst[6:0];
    assign w_rd     = issue_inst[11:7];
    assign w_funct3 = issue_inst[14:12];
    assign w_unused = ^{issue_inst[31:15], issue_addr[27:2]};

    always_comb begin
        w_is_wr   = 1'b0;
        w_sel_pc4 = 1'b0;
        w_is_load = 1'b0;
        case (w_opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: w_is_wr = 1'b1;
            OPC_JAL, OPC_JALR: begin
                w_is_wr   = 1'b1;
                w_sel_pc4 = 1'b1;
            end
            OPC_LOAD: w_is_load = is_load_f3(w_funct3);
            default: ;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    assign w_misalign = w_is_load &&
        ((((w_funct3 == F3_LH) || (w_funct3 == F3_LHU)) && issue_addr[0]) ||
         ((w_funct3 == F3_LW) && (issue_addr[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_enq_load = w_is_load && !w_misalign;
    assign w_new_desc = make_desc(w_rd, w_funct3, issue_addr[31:28], issue_addr[1:0]);
    assign w_head     = r_q[r_head];

    always_comb begin
        w_head_src_oh = 3'b000;
        w_rsp_word    = '0;
        case (w_head.src)
            SRC_IO:   begin w_head_src_oh = 3'b001; w_rsp_word = rsp_data[0*XLEN +: XLEN]; end
            SRC_DMEM: begin w_head_src_oh = 3'b010; w_rsp_word = rsp_data[1*XLEN +: XLEN]; end
            SRC_BIOS: begin w_head_src_oh = 3'b100; w_rsp_word = rsp_data[2*XLEN +: XLEN]; end
            default: ;
        endcase
        // Unmapped loads listen to no source and return zero.
        if (w_head.unmapped) begin
            w_head_src_oh = 3'b000;
            w_rsp_word    = '0;
        end
    end

    assign w_head_done = (r_count != '0) &&
                         (w_head.unmapped || ((rsp_valid & w_head_src_oh) != 3'b000));

    // A completing load owns the write port, so only a load that goes straight
    // into the queue may issue alongside it; that also lets a full queue
    // accept a load in the same cycle the head leaves.
    assign w_waw       = w_is_wr && (w_rd != 5'd0) && r_pending_mask[w_rd];
    assign issue_ready = !((w_enq_load && (r_count == FULL_CNT) && !w_head_done) ||
                           (!w_enq_load && w_head_done) ||
                           w_waw);
    assign w_fire = issue_valid && issue_ready;
    assign w_enq  = w_fire && w_enq_load;
    assign w_deq  = w_head_done;

    wb_load_fmt #(.XLEN(XLEN)) u_fmt (
        .i_word   (w_rsp_word),
        .i_off    (w_head.off),
        .i_funct3 (w_head.funct3),
        .o_data   (w_fmt_data)
    );

    // Mask of the queue as it will look after this cycle's enqueue/dequeue;
    // an entry leaving while another with the same rd remains keeps the bit.
    always_comb begin
        w_mask_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_enq && (r_tail == PW'(i)))
                w_mask_next[w_new_desc.rd] = 1'b1;
            else if (r_vld[i] && !(w_deq && (r_head == PW'(i))))
                w_mask_next[r_q[i].rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_deq) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: queue payload has no reset; r_vld and r_count gate every use, and
    // leaving storage unreset keeps it out of the reset tree.
    always_ff @(posedge clk) begin
        if (w_enq) r_q[r_tail] <= w_new_desc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_pending_mask <= '0;
        end else begin
            r_pending_mask <= w_mask_next;
            if (w_deq) begin
                r_wb_valid <= (w_head.rd != 5'd0);
                r_wb_rd    <= w_head.rd;
                r_wb_data  <= w_fmt_data;
            end else if (w_fire && w_is_wr) begin
                r_wb_valid <= (w_rd != 5'd0);
                r_wb_rd    <= w_rd;
                r_wb_data  <= w_sel_pc4 ? issue_pc4 : issue_alu;
            end else begin
                r_wb_valid <= 1'b0;
            end
        end
    end

`ifdef MISALIGN_CHECK_EN
    logic r_load_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_load_err <= 1'b0;
        else        r_load_err <= w_fire && w_misalign;
    end
    assign load_err = r_load_err;
`else
    assign load_err = 1'b0;
`endif

    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign pending_mask = r_pending_mask;

    // A response on a source the head is not waiting for is dropped.
    a_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        (r_count != '0) |-> ((rsp_valid & ~w_head_src_oh) == 3'b000));

endmodule

// File: tb/tb_wb_load_tracker.sv
module tb_wb_load_tracker;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_inst, issue_addr, issue_alu, issue_pc4;
    logic [2:0]  rsp_valid;
    logic [95:0] rsp_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] pending_mask;
    logic        load_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;
    wb_exp_t sb[$];
    wb_exp_t m_exp;

    typedef struct {
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic        exp_valid;
        logic [31:0] exp_data;
    } alu_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [2:0]  rsp;
        logic [31:0] word;
        logic        exp_valid;
        logic [31:0] exp_data;
    } ld_vec_t;

    alu_vec_t av[10];
    ld_vec_t  lv[12];

    wb_load_tracker #(.DEPTH(4), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_inst   (issue_inst),
        .issue_addr   (issue_addr),
        .issue_alu    (issue_alu),
        .issue_pc4    (issue_pc4),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .pending_mask (pending_mask),
        .load_err     (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3);
        return {17'h0, f3, rd, opc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_inst  = 32'h0;
        rsp_valid   = 3'b000;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] alu, input logic [31:0] pc4);
        issue_valid = 1'b1;
        issue_inst  = inst;
        issue_addr  = addr;
        issue_alu   = alu;
        issue_pc4   = pc4;
    endtask

    // Response on the selected sources; every other lane carries the inverse
    // word so a wrong lane select shows up in the data.
    task automatic respond(input logic [2:0] src, input logic [31:0] word);
        rsp_valid = src;
        for (int k = 0; k < 3; k++)
            rsp_data[k*32 +: 32] = src[k] ? word : ~word;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        wb_exp_t e;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    // Scoreboard: every register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_write: got rd=%0d data=0x%08h, required no write", wb_rd, wb_data);
            end else begin
                m_exp = sb.pop_front();
                check("sb_rd", 32'(wb_rd), 32'(m_exp.rd));
                check("sb_data", wb_data, m_exp.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active, required to finish within time limit");
        $fatal(1);
    end

    initial begin
        av[0] = '{7'b0010011, 5'd5,  32'h0000_0010, 32'h0000_0004, 1'b1, 32'h0000_0010};
        av[1] = '{7'b0110011, 5'd9,  32'hDEAD_BEEF, 32'h0000_0008, 1'b1, 32'hDEAD_BEEF};
        av[2] = '{7'b0110111, 5'd10, 32'h1234_5000, 32'h0000_000C, 1'b1, 32'h1234_5000};
        av[3] = '{7'b0010111, 5'd11, 32'h8000_0004, 32'h0000_0010, 1'b1, 32'h8000_0004};
        av[4] = '{7'b1101111, 5'd1,  32'h5555_5555, 32'h0000_0104, 1'b1, 32'h0000_0104};
        av[5] = '{7'b1100111, 5'd2,  32'hAAAA_AAAA, 32'h0000_0200, 1'b1, 32'h0000_0200};
        av[6] = '{7'b0010011, 5'd0,  32'h0000_0077, 32'h0000_0000, 1'b0, 32'h0};
        av[7] = '{7'b0100011, 5'd5,  32'h0000_0033, 32'h0000_0000, 1'b0, 32'h0};
        av[8] = '{7'b1100011, 5'd6,  32'h0000_0044, 32'h0000_0000, 1'b0, 32'h0};
        av[9] = '{7'b1111111, 5'd7,  32'h0000_0055, 32'h0000_0000, 1'b0, 32'h0};

        lv[0]  = '{3'b000, 5'd6,  32'h1000_0003, 3'b010, 32'h80FF_FFFF, 1'b1, 32'hFFFF_FF80};
        lv[1]  = '{3'b100, 5'd6,  32'h1000_0003, 3'b010, 32'h80FF_FFFF, 1'b1, 32'h0000_0080};
        lv[2]  = '{3'b000, 5'd3,  32'h8000_0001, 3'b001, 32'h0000_7F00, 1'b1, 32'h0000_007F};
        lv[3]  = '{3'b001, 5'd12, 32'h8000_0002, 3'b001, 32'h1234_8765, 1'b1, 32'h0000_1234};
        lv[4]  = '{3'b001, 5'd12, 32'h1000_0000, 3'b010, 32'h0000_8765, 1'b1, 32'hFFFF_8765};
        lv[5]  = '{3'b101, 5'd13, 32'h4000_0000, 3'b100, 32'hABCD_F00D, 1'b1, 32'h0000_F00D};
        lv[6]  = '{3'b101, 5'd13, 32'h4000_0002, 3'b100, 32'hABCD_F00D, 1'b1, 32'h0000_ABCD};
        lv[7]  = '{3'b010, 5'd14, 32'h3000_0004, 3'b010, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE};
        lv[8]  = '{3'b100, 5'd15, 32'h1000_0002, 3'b010, 32'h00AB_0000, 1'b1, 32'h0000_00AB};
        lv[9]  = '{3'b010, 5'd13, 32'h2000_0000, 3'b000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
        lv[10] = '{3'b010, 5'd0,  32'h1000_0000, 3'b010, 32'h1234_5678, 1'b0, 32'h0000_0000};
        lv[11] = '{3'b010, 5'd9,  32'hF000_0008, 3'b000, 32'h0BAD_0BAD, 1'b1, 32'h0000_0000};

        // Reset state
        rst_n = 1'b0;
        issue_addr = '0; issue_alu = '0; issue_pc4 = '0; rsp_data = '0;
        idle();
        #1;
        step();
        step();
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_pending", pending_mask, 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_ready", 32'(issue_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Single-cycle writers and non-writers
        for (int i = 0; i < 10; i++) begin
            drive(mk(av[i].opc, av[i].rd, 3'b000), 32'h0, av[i].alu, av[i].pc4);
            #1;
            check("alu_ready", 32'(issue_ready), 32'd1);
            if (av[i].exp_valid) push(av[i].rd, av[i].exp_data);
            step();
            idle();
            check("alu_wb_valid", 32'(wb_valid), 32'(av[i].exp_valid));
            if (av[i].exp_valid) begin
                check("alu_wb_rd", 32'(wb_rd), 32'(av[i].rd));
                check("alu_wb_data", wb_data, av[i].exp_data);
            end
        end

        // Loads at minimum latency: issue N, response N+1, writeback N+2
        for (int i = 0; i < 12; i++) begin
            drive(mk(7'b0000011, lv[i].rd, lv[i].f3), lv[i].addr, 32'h0, 32'h0);
            #1;
            check("ld_ready", 32'(issue_ready), 32'd1);
            step();
            idle();
            check("ld_wb_idle", 32'(wb_valid), 32'd0);
            if (lv[i].rd != 5'd0)
                check("ld_pending", pending_mask, 32'h1 << lv[i].rd);
            respond(lv[i].rsp, lv[i].word);
            if (lv[i].exp_valid) push(lv[i].rd, lv[i].exp_data);
            step();
            rsp_valid = 3'b000;
            check("ld_wb_valid", 32'(wb_valid), 32'(lv[i].exp_valid));
            if (lv[i].exp_valid) begin
                check("ld_wb_rd", 32'(wb_rd), 32'(lv[i].rd));
                check("ld_wb_data", wb_data, lv[i].exp_data);
            end
            check("ld_pending_clr", pending_mask, 32'h0);
        end

        // LB with the response two cycles after issue
        drive(mk(7'b0000011, 5'd6, 3'b000), 32'h1000_0003, 32'h0, 32'h0);
        step();
        idle();
        step();
        check("lb2_no_wb", 32'(wb_valid), 32'd0);
        respond(3'b010, 32'h80FF_FFFF);
        push(5'd6, 32'hFFFF_FF80);
        step();
        rsp_valid = 3'b000;
        check("lb2_wb_data", wb_data, 32'hFFFF_FF80);

        // Full queue: four loads park, the fifth waits for the head to leave
        for (int i = 0; i < 4; i++) begin
            drive(mk(7'b0000011, 5'(20 + i), 3'b010), 32'h1000_0000 + 32'(4 * i), 32'h0, 32'h0);
            #1;
            check("full_fill_ready", 32'(issue_ready), 32'd1);
            step();
        end
        drive(mk(7'b0000011, 5'd24, 3'b010), 32'h1000_0010, 32'h0, 32'h0);
        #1;
        check("full_blocks_5th", 32'(issue_ready), 32'd0);
        step();
        check("full_pending", pending_mask, 32'h00F0_0000);
        respond(3'b010, 32'h0000_0020);
        #1;
        check("full_enq_on_deq", 32'(issue_ready), 32'd1);
        push(5'd20, 32'h0000_0020);
        step();
        idle();
        check("full_head_wb_rd", 32'(wb_rd), 32'd20);
        check("full_pending_shift", pending_mask, 32'h01E0_0000);
        for (int k = 1; k <= 4; k++) begin
            respond(3'b010, 32'h0000_0020 + 32'(k));
            push(5'(20 + k), 32'h0000_0020 + 32'(k));
            step();
        end
        rsp_valid = 3'b000;
        check("full_drained_pending", pending_mask, 32'h0);

        // WAW stall on a pending load destination
        drive(mk(7'b0000011, 5'd7, 3'b010), 32'h1000_0010, 32'h0, 32'h0);
        step();
        drive(mk(7'b0110011, 5'd7, 3'b000), 32'h0, 32'h0000_0077, 32'h0);
        #1;
        check("waw_stall", 32'(issue_ready), 32'd0);
        step();
        drive(mk(7'b0110011, 5'd8, 3'b000), 32'h0, 32'h0000_0088, 32'h0);
        #1;
        check("waw_other_rd_ready", 32'(issue_ready), 32'd1);
        push(5'd8, 32'h0000_0088);
        step();
        check("waw_other_rd_wb", wb_data, 32'h0000_0088);
        drive(mk(7'b0110011, 5'd7, 3'b000), 32'h0, 32'h0000_0077, 32'h0);
        respond(3'b010, 32'h7070_7070);
        #1;
        check("waw_port_owned", 32'(issue_ready), 32'd0);
        push(5'd7, 32'h7070_7070);
        step();
        rsp_valid = 3'b000;
        check("waw_load_wb", wb_data, 32'h7070_7070);
        #1;
        check("waw_released", 32'(issue_ready), 32'd1);
        push(5'd7, 32'h0000_0077);
        step();
        idle();
        check("waw_alu_wb", wb_data, 32'h0000_0077);

        // Head response and an unrelated ALU issue in the same cycle
        drive(mk(7'b0000011, 5'd14, 3'b010), 32'h1000_0000, 32'h0, 32'h0);
        step();
        drive(mk(7'b0010011, 5'd15, 3'b000), 32'h0, 32'h0000_0015, 32'h0);
        respond(3'b010, 32'h0000_0E0E);
        #1;
        check("same_cycle_ready", 32'(issue_ready), 32'd0);
        push(5'd14, 32'h0000_0E0E);
        step();
        rsp_valid = 3'b000;
        check("same_cycle_load_rd", 32'(wb_rd), 32'd14);
        #1;
        check("same_cycle_alu_ready", 32'(issue_ready), 32'd1);
        push(5'd15, 32'h0000_0015);
        step();
        idle();
        check("same_cycle_alu_rd", 32'(wb_rd), 32'd15);

        // Misaligned halfword
        drive(mk(7'b0000011, 5'd16, 3'b001), 32'h1000_0001, 32'h0, 32'h0);
        #1;
        check("mis_ready", 32'(issue_ready), 32'd1);
        step();
        idle();
`ifdef MISALIGN_CHECK_EN
        check("mis_load_err", 32'(load_err), 32'd1);
        check("mis_no_wb", 32'(wb_valid), 32'd0);
        check("mis_not_queued", pending_mask, 32'h0);
        step();
        check("mis_err_pulse", 32'(load_err), 32'd0);
`else
        check("mis_no_err", 32'(load_err), 32'd0);
        check("mis_queued", pending_mask, 32'h0001_0000);
        respond(3'b010, 32'h1111_8001);
        push(5'd16, 32'hFFFF_8001);
        step();
        rsp_valid = 3'b000;
        check("mis_forced_half", wb_data, 32'hFFFF_8001);
`endif

        // Reset with a load outstanding, then a late response
        drive(mk(7'b0000011, 5'd17, 3'b010), 32'h1000_0000, 32'h0, 32'h0);
        step();
        idle();
        check("rstmid_pending", pending_mask, 32'h0002_0000);
        rst_n = 1'b0;
        #1;
        check("rstmid_cleared", pending_mask, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        respond(3'b010, 32'h1717_1717);
        step();
        rsp_valid = 3'b000;
        check("rstmid_rsp_ignored", 32'(wb_valid), 32'd0);
        check("rstmid_ready", 32'(issue_ready), 32'd1);

        step();
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
